// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, ALU operand select,
// branch/jump target generation and load-use hazard detection.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_e,
    input  logic        flush_e,
    input  logic        valid_d,
    input  logic [31:0] rd1_d,
    input  logic [31:0] rd2_d,
    input  logic [31:0] imm_d,
    input  logic [31:0] pc_d,
    input  logic [31:0] pc_plus4_d,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic [4:0]  rd_d,
    input  logic [5:0]  alu_control_d,
    input  logic        alu_src_d,
    input  logic        reg_write_d,
    input  logic        mem_write_d,
    input  logic        branch_d,
    input  logic        jump_d,
    input  logic        jalr_d,
    input  logic [1:0]  result_src_d,
    input  logic [4:0]  rd_m,
    input  logic [4:0]  rd_w,
    input  logic        reg_write_m,
    input  logic        reg_write_w,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] result_w,
    output logic [31:0] src_a_e,
    output logic [31:0] src_b_e,
    output logic [5:0]  alu_control_e,
    output logic [31:0] write_data_e,
    output logic [31:0] pc_target_e,
    output logic [31:0] pc_plus4_e,
    output logic [4:0]  rd_e,
    output logic [1:0]  result_src_e,
    output logic        reg_write_e,
    output logic        mem_write_e,
    output logic        branch_e,
    output logic        jump_e,
    output logic        valid_e,
    output logic        load_use_stall
);

    // Control fields are zeroed by flush or by an invalid decode slot;
    // datapath fields simply follow decode whenever the stage loads.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [1:0] result_src;
        logic [4:0] rd;
    } ctrl_t;

    typedef struct packed {
        logic        alu_src;
        logic [5:0]  alu_control;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } data_t;

    ctrl_t ctrl_e_q, ctrl_e_d;
    data_t data_e_q, data_e_d;

    always_comb begin
        ctrl_e_d = ctrl_e_q;
        data_e_d = data_e_q;
        if (flush_e) begin
            ctrl_e_d = '0;
        end else if (!stall_e) begin
            data_e_d.alu_src     = alu_src_d;
            data_e_d.alu_control = alu_control_d;
            data_e_d.rs1         = rs1_d;
            data_e_d.rs2         = rs2_d;
            data_e_d.rd1         = rd1_d;
            data_e_d.rd2         = rd2_d;
            data_e_d.imm         = imm_d;
            data_e_d.pc          = pc_d;
            data_e_d.pc_plus4    = pc_plus4_d;
            ctrl_e_d             = '0;
            if (valid_d) begin
                ctrl_e_d.valid      = 1'b1;
                ctrl_e_d.reg_write  = reg_write_d;
                ctrl_e_d.mem_write  = mem_write_d;
                ctrl_e_d.branch     = branch_d;
                ctrl_e_d.jump       = jump_d;
                ctrl_e_d.jalr       = jalr_d;
                ctrl_e_d.result_src = result_src_d;
                ctrl_e_d.rd         = rd_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_e_q <= '0;
            data_e_q <= '0;
        end else begin
            ctrl_e_q <= ctrl_e_d;
            data_e_q <= data_e_d;
        end
    end

    // MEM beats WB; x0 is never forwarded.
    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] reg_val,
                                        input logic [4:0] rdm, input logic rwm, input logic [31:0] valm,
                                        input logic [4:0] rdw, input logic rww, input logic [31:0] valw);
        logic [31:0] v;
        v = reg_val;
        if (rwm && (rdm != 5'd0) && (rdm == rs))      v = valm;
        else if (rww && (rdw != 5'd0) && (rdw == rs)) v = valw;
        return v;
    endfunction

    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] b_sel;
    logic        is_shift;
    logic [31:0] target_sum;

    always_comb begin
        fwd_a = fwd(data_e_q.rs1, data_e_q.rd1, rd_m, reg_write_m, alu_result_m,
                    rd_w, reg_write_w, result_w);
        fwd_b = fwd(data_e_q.rs2, data_e_q.rd2, rd_m, reg_write_m, alu_result_m,
                    rd_w, reg_write_w, result_w);
        b_sel = data_e_q.alu_src ? data_e_q.imm : fwd_b;
        is_shift = (data_e_q.alu_control == 6'b000110) ||
                   (data_e_q.alu_control == 6'b001000) ||
                   (data_e_q.alu_control == 6'b001001);
        src_b_e = is_shift ? {27'd0, b_sel[4:0]} : b_sel;
        src_a_e = fwd_a;
        write_data_e = fwd_b;
        target_sum = (ctrl_e_q.jalr ? fwd_a : data_e_q.pc) + data_e_q.imm;
        pc_target_e = {target_sum[31:1], target_sum[0] & ~ctrl_e_q.jalr};
    end

    // The hazard unit answers this request with flush_e; no bubble is made here.
    assign load_use_stall = valid_d && ctrl_e_q.valid && (ctrl_e_q.result_src == 2'b01) &&
                            (ctrl_e_q.rd != 5'd0) &&
                            ((ctrl_e_q.rd == rs1_d) || (ctrl_e_q.rd == rs2_d));

    assign alu_control_e = data_e_q.alu_control;
    assign pc_plus4_e    = data_e_q.pc_plus4;
    assign rd_e          = ctrl_e_q.rd;
    assign result_src_e  = ctrl_e_q.result_src;
    assign reg_write_e   = ctrl_e_q.reg_write;
    assign mem_write_e   = ctrl_e_q.mem_write;
    assign branch_e      = ctrl_e_q.branch;
    assign jump_e        = ctrl_e_q.jump;
    assign valid_e       = ctrl_e_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for operand/target paths plus
// hand-written sequences for reset, load-use, stall/flush and valid gating.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_e, flush_e, valid_d;
    logic [31:0] rd1_d, rd2_d, imm_d, pc_d, pc_plus4_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [5:0]  alu_control_d;
    logic        alu_src_d, reg_write_d, mem_write_d, branch_d, jump_d, jalr_d;
    logic [1:0]  result_src_d;
    logic [4:0]  rd_m, rd_w;
    logic        reg_write_m, reg_write_w;
    logic [31:0] alu_result_m, result_w;
    logic [31:0] src_a_e, src_b_e, write_data_e, pc_target_e, pc_plus4_e;
    logic [5:0]  alu_control_e;
    logic [4:0]  rd_e;
    logic [1:0]  result_src_e;
    logic        reg_write_e, mem_write_e, branch_e, jump_e, valid_e, load_use_stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .alu_control_d(alu_control_d),
        .alu_src_d(alu_src_d), .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
        .branch_d(branch_d), .jump_d(jump_d), .jalr_d(jalr_d), .result_src_d(result_src_d),
        .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .alu_result_m(alu_result_m), .result_w(result_w),
        .src_a_e(src_a_e), .src_b_e(src_b_e), .alu_control_e(alu_control_e),
        .write_data_e(write_data_e), .pc_target_e(pc_target_e), .pc_plus4_e(pc_plus4_e),
        .rd_e(rd_e), .result_src_e(result_src_e), .reg_write_e(reg_write_e),
        .mem_write_e(mem_write_e), .branch_e(branch_e), .jump_e(jump_e),
        .valid_e(valid_e), .load_use_stall(load_use_stall)
    );

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [31:0] rd1, rd2, imm, pc;
        logic [5:0]  ctrl;
        logic        alu_src, jalr;
        logic [4:0]  rdm;  logic rwm; logic [31:0] valm;
        logic [4:0]  rdw;  logic rww; logic [31:0] valw;
        logic [31:0] exp_a, exp_b, exp_wd, exp_tgt;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_d();
        valid_d = 0; rd1_d = 0; rd2_d = 0; imm_d = 0; pc_d = 0; pc_plus4_d = 0;
        rs1_d = 0; rs2_d = 0; rd_d = 0; alu_control_d = 0; alu_src_d = 0;
        reg_write_d = 0; mem_write_d = 0; branch_d = 0; jump_d = 0; jalr_d = 0;
        result_src_d = 0;
    endtask

    task automatic idle_mw();
        rd_m = 0; rd_w = 0; reg_write_m = 0; reg_write_w = 0; alu_result_m = 0; result_w = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //        rs1 rs2 rd1           rd2           imm           pc            ctrl     src jalr rdm rwm valm          rdw rww valw          exp_a         exp_b         exp_wd        exp_tgt
        vecs[0] = '{5, 6, 32'h0000_AAAA, 32'h0000_BBBB, 32'h20,       32'h100,      6'b000000, 0, 0, 5, 1, 32'h11,       5, 1, 32'h22,       32'h11,       32'h0000_BBBB, 32'h0000_BBBB, 32'h120};
        vecs[1] = '{5, 6, 32'h0000_AAAA, 32'h0000_BBBB, 32'h20,       32'h100,      6'b000000, 0, 0, 5, 0, 32'h11,       5, 1, 32'h22,       32'h22,       32'h0000_BBBB, 32'h0000_BBBB, 32'h120};
        vecs[2] = '{1, 0, 32'h5,         32'h0,         32'h0,        32'h200,      6'b000000, 0, 0, 0, 1, 32'hDEAD,     0, 0, 32'h0,        32'h5,        32'h0,         32'h0,         32'h200};
        vecs[3] = '{1, 0, 32'h5,         32'h0,         32'hFFFF_FFE3, 32'h0,       6'b001001, 1, 0, 0, 1, 32'hDEAD,     0, 0, 32'h0,        32'h5,        32'h3,         32'h0,         32'hFFFF_FFE3};
        vecs[4] = '{2, 3, 32'h7,         32'h8,         32'hABCD_E000, 32'h1000,    6'b000111, 1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h7,        32'hABCD_E000, 32'h8,         32'hABCD_F000};
        vecs[5] = '{3, 0, 32'h0,         32'h0,         32'h4,        32'h400,      6'b000000, 1, 1, 3, 1, 32'h2001,     0, 0, 32'h0,        32'h2001,     32'h4,         32'h0,         32'h2004};
        vecs[6] = '{3, 0, 32'hFFFF_FFFF, 32'h0,         32'h2,        32'h400,      6'b000000, 1, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'hFFFF_FFFF, 32'h2,        32'h0,         32'h0};
        vecs[7] = '{0, 9, 32'h0,         32'h99,        32'h10,       32'h10,       6'b000000, 1, 0, 0, 0, 32'h0,        9, 1, 32'h77,       32'h0,        32'h10,        32'h77,        32'h20};
        vecs[8] = '{0, 9, 32'h0,         32'h99,        32'h10,       32'h10,       6'b000000, 1, 0, 0, 0, 32'h0,        9, 0, 32'h77,       32'h0,        32'h10,        32'h99,        32'h20};
        vecs[9] = '{0, 4, 32'h0,         32'hFFFF_FFFF, 32'h0,        32'h0,        6'b000110, 0, 0, 4, 1, 32'h1234_5678, 4, 1, 32'h5,        32'h0,        32'h18,        32'h1234_5678, 32'h0};

        // Reset with arbitrary decode inputs
        rst = 0; stall_e = 0; flush_e = 0; idle_mw();
        valid_d = 1; reg_write_d = 1; mem_write_d = 1; branch_d = 1; jump_d = 1; jalr_d = 0;
        rd_d = 5'($urandom_range(1, 31)); rs1_d = 5'($urandom_range(1, 31)); rs2_d = rd_d;
        alu_control_d = 6'($urandom_range(1, 63)); result_src_d = 2'b01; alu_src_d = 1;
        rd1_d = $urandom; rd2_d = $urandom; imm_d = $urandom; pc_d = $urandom; pc_plus4_d = $urandom;
        step(); step();
        check("rst_valid", 32'(valid_e), 0);
        check("rst_reg_write", 32'(reg_write_e), 0);
        check("rst_rd", 32'(rd_e), 0);
        check("rst_alu_control", 32'(alu_control_e), 0);
        check("rst_load_use", 32'(load_use_stall), 0);
        check("rst_src_a", src_a_e, 0);
        check("rst_src_b", src_b_e, 0);
        check("rst_target", pc_target_e, 0);
        rst = 1;

        // Vector table: load one instruction, then check the combinational paths
        for (int i = 0; i < 10; i++) begin
            idle_d();
            valid_d = 1; reg_write_d = 1; rd_d = 5'd1;
            rs1_d = vecs[i].rs1; rs2_d = vecs[i].rs2; rd1_d = vecs[i].rd1; rd2_d = vecs[i].rd2;
            imm_d = vecs[i].imm; pc_d = vecs[i].pc; alu_control_d = vecs[i].ctrl;
            alu_src_d = vecs[i].alu_src; jalr_d = vecs[i].jalr;
            rd_m = vecs[i].rdm; reg_write_m = vecs[i].rwm; alu_result_m = vecs[i].valm;
            rd_w = vecs[i].rdw; reg_write_w = vecs[i].rww; result_w = vecs[i].valw;
            step();
            idle_d();
            #1;
            check($sformatf("v%0d_src_a", i), src_a_e, vecs[i].exp_a);
            check($sformatf("v%0d_src_b", i), src_b_e, vecs[i].exp_b);
            check($sformatf("v%0d_write_data", i), write_data_e, vecs[i].exp_wd);
            check($sformatf("v%0d_target", i), pc_target_e, vecs[i].exp_tgt);
            check($sformatf("v%0d_alu_control", i), 32'(alu_control_e), 32'(vecs[i].ctrl));
        end

        // Load-use detection
        idle_d(); idle_mw();
        valid_d = 1; reg_write_d = 1; result_src_d = 2'b01; rd_d = 5'd7;
        step();
        idle_d();
        valid_d = 1; rs1_d = 5'd3; rs2_d = 5'd7; #1;
        check("lu_rs2", 32'(load_use_stall), 1);
        valid_d = 0; #1;
        check("lu_invalid_d", 32'(load_use_stall), 0);
        valid_d = 1; rs1_d = 5'd7; rs2_d = 5'd8; #1;
        check("lu_rs1", 32'(load_use_stall), 1);
        rs1_d = 5'd9; #1;
        check("lu_no_match", 32'(load_use_stall), 0);
        idle_d();
        valid_d = 1; reg_write_d = 1; result_src_d = 2'b01; rd_d = 5'd0;
        step();
        idle_d(); valid_d = 1; #1;
        check("lu_rd_x0", 32'(load_use_stall), 0);
        idle_d();
        valid_d = 1; reg_write_d = 1; result_src_d = 2'b00; rd_d = 5'd7;
        step();
        idle_d(); valid_d = 1; rs1_d = 5'd7; #1;
        check("lu_not_load", 32'(load_use_stall), 0);

        // Stall holds, forwarding stays live, flush beats stall
        idle_d(); idle_mw();
        valid_d = 1; reg_write_d = 1; rd_d = 5'd10; rs1_d = 5'd11; rd1_d = 32'h1234;
        pc_plus4_d = 32'h104; mem_write_d = 1;
        step();
        stall_e = 1;
        for (int c = 0; c < 3; c++) begin
            valid_d = 1; rd_d = 5'(20 + c); rs1_d = 5'd2; rd1_d = $urandom; pc_plus4_d = $urandom;
            step();
            check($sformatf("stall%0d_rd", c), 32'(rd_e), 10);
            check($sformatf("stall%0d_valid", c), 32'(valid_e), 1);
            check($sformatf("stall%0d_pc4", c), pc_plus4_e, 32'h104);
            check($sformatf("stall%0d_src_a", c), src_a_e, 32'h1234);
        end
        rd_m = 5'd11; reg_write_m = 1; alu_result_m = 32'h55; #1;
        check("stall_fwd_live", src_a_e, 32'h55);
        idle_mw();
        flush_e = 1;
        step();
        check("flush_valid", 32'(valid_e), 0);
        check("flush_reg_write", 32'(reg_write_e), 0);
        check("flush_mem_write", 32'(mem_write_e), 0);
        check("flush_rd", 32'(rd_e), 0);
        stall_e = 0; flush_e = 0;

        // Invalid decode slot loads as a bubble
        idle_d();
        valid_d = 0; reg_write_d = 1; mem_write_d = 1; jump_d = 1; rd_d = 5'd5;
        step();
        check("inv_valid", 32'(valid_e), 0);
        check("inv_reg_write", 32'(reg_write_e), 0);
        check("inv_jump", 32'(jump_e), 0);
        check("inv_rd", 32'(rd_e), 0);

        // Reset asserted mid-stall
        idle_d();
        valid_d = 1; reg_write_d = 1; branch_d = 1; rd_d = 5'd12;
        step();
        check("pre_rst_valid", 32'(valid_e), 1);
        check("pre_rst_branch", 32'(branch_e), 1);
        stall_e = 1; rst = 0;
        step();
        check("rst_stall_valid", 32'(valid_e), 0);
        check("rst_stall_rd", 32'(rd_e), 0);
        rst = 1; stall_e = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register and operand-select stage between decode and the execute-stage ALU of the 32-bit RISC-V core. It captures decoded operands and control each cycle and applies MEM/WB forwarding to produce the ALU's signed A/B operands and 6-bit ALU control. It also computes the branch/jump target and flags load-use hazards back to decode. It honours stall and flush from the hazard unit.

## Interface
- No parameters; XLEN fixed at 32, register index 5 bits, ALU control 6 bits.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- stall_e  in  1  hold all E registers
- flush_e  in  1  insert bubble into E
- valid_d  in  1  decode slot holds a real instruction
- rd1_d, rd2_d, imm_d, pc_d, pc_plus4_d  in  32 each  register-file reads, extended immediate, PC, PC+4
- rs1_d, rs2_d, rd_d  in  5 each  source/destination indices
- alu_control_d  in  6  ALU opcode, passed to ALU unchanged
- alu_src_d, reg_write_d, mem_write_d, branch_d, jump_d, jalr_d  in  1 each  decoded controls
- result_src_d  in  2  00 ALU, 01 load data, 10 PC+4
- rd_m, rd_w  in  5 each; reg_write_m, reg_write_w  in  1 each  forwarding tags
- alu_result_m, result_w  in  32 each  forwarding data
- src_a_e, src_b_e  out  32 each  ALU operands A, B
- alu_control_e  out  6  ALU opcode
- write_data_e  out  32  forwarded rs2 value for stores
- pc_target_e, pc_plus4_e  out  32 each  branch/jump target, link value
- rd_e  out  5; result_src_e  out  2
- reg_write_e, mem_write_e, branch_e, jump_e, valid_e  out  1 each
- load_use_stall  out  1  request to stall decode/fetch

## Operation
- Registered fields: every *_d input except those used only combinationally, stored as *_e.
- Update priority at each edge: rst low > flush_e > stall_e > load.
  - Reset: all registers 0.
  - Flush: valid_e, reg_write_e, mem_write_e, branch_e, jump_e and jalr_e go to 0, rd_e goes to 0. Datapath registers may hold any value.
  - Stall: hold.
  - Load: capture *_d. If valid_d=0, the controls are captured as 0, as in a flush.
- Forwarding for rs1 (fwd_a) and rs2 (fwd_b), combinational from registered rs*_e:
  - MEM: if reg_write_m and rd_m≠0 and rd_m==rs_e, select alu_result_m.
  - Else WB: if reg_write_w and rd_w≠0 and rd_w==rs_e, select result_w.
  - Else select the registered rdX_e.
  - MEM has priority over WB. x0 is never forwarded.
- src_a_e = fwd_a.
- src_b_e = alu_src_e ? imm_e : fwd_b.
  - When alu_control_e is 000110, 001000 or 001001 (sll/srl/sra), bits 31:5 of src_b_e are forced to 0.
  - lui (000111) receives imm_e on B unmodified.
- write_data_e = fwd_b, independent of alu_src_e.
- pc_target_e = (jalr_e ? fwd_a : pc_e) + imm_e, modulo 2^32. When jalr_e is set, bit 0 is cleared.
- load_use_stall = valid_e & result_src_e==01 & rd_e≠0 & (rd_e==rs1_d | rd_e==rs2_d), qualified by valid_d.
  - The stage does not self-insert the bubble. The hazard unit drives flush_e in response.

## Timing
- Capture latency: 1 cycle. Values on *_d at edge N appear on *_e outputs after edge N.
- Forwarding paths, src_a_e/src_b_e, write_data_e, pc_target_e and load_use_stall are combinational from current registers and M/W inputs. They settle within the same cycle.
- Reset value of every output: registered outputs 0.
  - src_a_e=0, src_b_e=0 and pc_target_e=0, provided the M/W tags are inactive.
  - load_use_stall=0.
- Simultaneous flush_e and stall_e: flush wins.
- rst asserted mid-stall: reset wins at the next edge.
- Forwarding is live during a stall. Held rs*_e keep tracking the changing M/W inputs every cycle.

## Test plan
- Reset: rst=0 for 2 cycles with arbitrary *_d -> valid_e=0, reg_write_e=0, rd_e=0, alu_control_e=0, load_use_stall=0.
- Forward priority: rs1_e=5, rd_m=5/reg_write_m=1/alu_result_m=0x11, rd_w=5/reg_write_w=1/result_w=0x22 -> src_a_e=0x11. Then reg_write_m=0 -> src_a_e=0x22.
- x0 guard and shift mask: rs2_e=0, rd_m=0, reg_write_m=1, rd2_e=0 -> src_b_e=0. Then alu_src=1, imm=0xFFFF_FFE3, alu_control=001001 -> src_b_e=0x0000_0003.
- Load-use: E holds load (result_src_e=01, rd_e=7), rs2_d=7, valid_d=1 -> load_use_stall=1. rd_e=0 -> load_use_stall=0.
- Stall vs flush: load ADD, then stall_e=1 for 3 cycles -> outputs held. Then stall_e=1 and flush_e=1 together -> valid_e=0, reg_write_e=0.
- Targets: pc=0x100, imm=0x20 -> pc_target_e=0x120. jalr, fwd_a=0x2001, imm=0x4 -> 0x2004. fwd_a=0xFFFF_FFFF, imm=2 -> 0x0000_0000 (wrap, bit 0 cleared).
